stream_fifo: RTL and testbench
==============================

# stream_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, programmable almost-full/almost-empty flags, a selectable overflow mode (backpressure or drop-and-count), synchronous flush and optional occupancy statistics. It buffers trace/event records between producer and consumer stages in the same clock domain. It is the general-purpose successor to the plain enable-based synchronous FIFO, and is first-word-fall-through: head data is presented without a read request.

## Interface
Parameters:
- `WIDTH`, 64, data width in bits.
- `DEPTH`, 16, entries; any value ≥ 2, power of two not required.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, pointer width (derived).
- `AF_THRESH`, `DEPTH-2`, `almost_full` asserts when count ≥ `AF_THRESH`.
- `AE_THRESH`, 2, `almost_empty` asserts when count ≤ `AE_THRESH`.
- `DROP_ON_FULL`, 0, 0 = backpressure via `in_ready`; 1 = `in_ready` tied 1, writes while full are discarded and counted.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `flush`, in, 1, synchronous clear of contents.
- `in_valid`, in, 1, producer has data.
- `in_ready`, out, 1, FIFO accepts data.
- `in_data`, in, `WIDTH`, write data.
- `out_valid`, out, 1, head entry valid (= !empty).
- `out_ready`, in, 1, consumer takes head.
- `out_data`, out, `WIDTH`, head entry.
- `count`, out, `ADDR_WIDTH+1`, current occupancy.
- `almost_full`, out, 1, count ≥ `AF_THRESH`.
- `almost_empty`, out, 1, count ≤ `AE_THRESH`.
- `drop_count`, out, 32, writes discarded while full, saturating.
- `stats_clr`, in, 1, clears statistics (stats build only).
- `high_water`, out, `ADDR_WIDTH+1`, maximum occupancy seen (stats build only).

## Operation
- Push = `in_valid && (count < DEPTH)`; pop = `out_valid && out_ready`. Push and pop both use the start-of-cycle count; pop in the same cycle does not free space for a push when full.
- `in_ready` = !full when `DROP_ON_FULL=0`; constant 1 when `DROP_ON_FULL=1`.
- Drop event: `DROP_ON_FULL=1 && in_valid && full` → data discarded, `drop_count` +1, saturating at 0xFFFF_FFFF. `drop_count` stays 0 when `DROP_ON_FULL=0`.
- Pointers wrap from `DEPTH-1` to 0, which gives correct wrap for non-power-of-two depths. Count is updated as +1 for push only, −1 for pop only, and unchanged for push+pop.
- `flush` has priority over push and pop: pointers and count go to 0 and any same-cycle push is ignored, not counted as a drop. `flush` does not clear the statistics.
- Memory contents are not reset. Only pointers, count and counters are reset.

## Timing
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `almost_full`=(`AF_THRESH`==0), `almost_empty`=1, `drop_count`=0, `high_water`=0. `out_data` is don't-care while `out_valid`=0.
- Write-to-read latency is one cycle: data pushed at edge N is on `out_data` with `out_valid`=1 after edge N.
- `out_data` = `mem[rd_ptr]` combinationally. It is stable while `out_valid && !out_ready`.
- All flags and `count` are registered-state-derived and reflect post-edge occupancy. There is no combinational path from `in_valid` or `out_ready` to `in_ready` or `out_valid`.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), and buffered entries are lost.

## Configuration
- `STREAM_FIFO_STATS_EN` defined:
  - `high_water` is updated each cycle to max(`high_water`, next count).
  - `stats_clr` zeroes `high_water` and `drop_count` on the next edge, with priority over a same-cycle increment.
- Macro undefined:
  - `high_water` is driven 0.
  - `stats_clr` is ignored.
  - `drop_count` still operates and is cleared only by reset.

## Structure
- Package `stream_fifo_pkg`:
  - `DROP_CNT_W`=32.
  - Typedef `drop_cnt_t`.
  - Enum `ovf_mode_e` {`OVF_BACKPRESSURE`, `OVF_DROP`}, used for `DROP_ON_FULL` semantics.
  - Function `ptr_inc(ptr, depth)` for wrap.
- Sub-module `stream_fifo_ram`: `DEPTH`×`WIDTH` register array with one synchronous write port and one asynchronous read port. It has no reset.

## Test plan
- Backpressure fill: `DEPTH`=16, push 0..19 continuously with `out_ready`=0 → `in_ready` falls after the 16th accept; count=16, `almost_full`=1 from count 14, `drop_count`=0.
- Drop mode: `DROP_ON_FULL`=1, push 0..19 with `out_ready`=0 → count=16, `drop_count`=4; draining yields 0..15 in order.
- Simultaneous push/pop at count=5 for 10 cycles → count stays 5 and output order is preserved. At full, push+pop → pop occurs, push is blocked, count=15.
- Wrap: `DEPTH`=12, stream 40 items with random `out_ready` → exact in-order output, with no loss or duplication across pointer wrap.
- Flush mid-stream at count=7 with a concurrent push → next cycle count=0, `out_valid`=0, `drop_count` unchanged. With stats enabled, `high_water`=7 retained, then `stats_clr` → 0.
- `rst_n` pulsed low with count=9 → outputs take reset values asynchronously. After release, a push of 0xA5 appears on `out_data` one cycle later.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for the stream_fifo block.
package stream_fifo_pkg;

  localparam int DROP_CNT_W = 32;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  // Behaviour when a write arrives while the FIFO is full.
  typedef enum logic {
    OVF_BACKPRESSURE = 1'b0,
    OVF_DROP         = 1'b1
  } ovf_mode_e;

  // Advance a pointer, wrapping from depth-1 back to 0 (works for any depth).
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    logic [31:0] nxt;
    if (ptr == (depth - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read
// port. Contents are intentionally not reset.
module stream_fifo_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture write data into the addressed entry.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides,
// almost-full/almost-empty flags, backpressure or drop-and-count overflow,
// synchronous flush. Define STREAM_FIFO_STATS_EN to enable the high-water
// statistic and the stats_clr input.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int AF_THRESH    = DEPTH - 2,
  parameter int AE_THRESH    = 2,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [31:0]           drop_count,
  input  logic                  stats_clr,
  output logic [ADDR_WIDTH:0]   high_water
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic             AF_RST  = (AF_THRESH == 0) ? 1'b1 : 1'b0;
  localparam ovf_mode_e OVF_MODE = (DROP_ON_FULL != 0) ? OVF_DROP : OVF_BACKPRESSURE;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  drop_cnt_t             drop_cnt_q, drop_cnt_d;

  logic full_s, push_s, pop_s, drop_s, we_s;

  // Handshake decode from start-of-cycle occupancy; flush suppresses push and drop.
  assign full_s = (count_q == DEPTH_C);
  assign push_s = in_valid && !full_s;
  assign pop_s  = (count_q != {CNT_W{1'b0}}) && out_ready;
  assign drop_s = (OVF_MODE == OVF_DROP) && in_valid && full_s && !flush;
  assign we_s   = push_s && !flush;

  stream_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  // Next pointers, occupancy and occupancy-derived flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {ADDR_WIDTH{1'b0}};
      rd_ptr_d = {ADDR_WIDTH{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end

    out_valid_d = (count_d != {CNT_W{1'b0}});
    af_d        = (count_d >= AF_C);
    ae_d        = (count_d <= AE_C);
    if (OVF_MODE == OVF_DROP) begin
      in_ready_d = 1'b1;
    end else begin
      in_ready_d = (count_d != DEPTH_C);
    end
  end

  // Next drop counter: saturating, optionally cleared by stats_clr.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
`ifdef STREAM_FIFO_STATS_EN
    if (stats_clr) begin
      drop_cnt_d = {DROP_CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + drop_cnt_t'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
`else
    if (drop_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + drop_cnt_t'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
`endif
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      af_q        <= AF_RST;
      ae_q        <= 1'b1;
      drop_cnt_q  <= {DROP_CNT_W{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef STREAM_FIFO_STATS_EN
  logic [CNT_W-1:0] hw_q, hw_d;

  // High-water mark tracks the largest post-edge occupancy; stats_clr wins.
  always_comb begin
    hw_d = hw_q;
    if (stats_clr) begin
      hw_d = {CNT_W{1'b0}};
    end else if (count_d > hw_q) begin
      hw_d = count_d;
    end else begin
      hw_d = hw_q;
    end
  end

  // High-water register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q <= {CNT_W{1'b0}};
    end else begin
      hw_q <= hw_d;
    end
  end

  assign high_water = hw_q;
`else
  logic unused_stats_clr_s;
  assign unused_stats_clr_s = stats_clr;
  assign high_water         = {CNT_W{1'b0}};
`endif

  assign count        = count_q;
  assign out_valid    = out_valid_q;
  assign in_ready     = in_ready_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo. Three instances share one stimulus:
// DEPTH=16 backpressure, DEPTH=16 drop mode, DEPTH=12 backpressure.
// Each is compared every cycle against a list-based occupancy model.
module tb_stream_fifo;

  localparam int W = 64;
`ifdef STREAM_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready, stats_clr;
  logic [W-1:0]  in_data;

  logic          rdy   [3];
  logic          ovld  [3];
  logic [W-1:0]  odata [3];
  logic [4:0]    cnt   [3];
  logic          af    [3];
  logic          ae    [3];
  logic [31:0]   dcnt  [3];
  logic [4:0]    hw    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_fifo #(.WIDTH(W), .DEPTH(16), .DROP_ON_FULL(0)) u_bp (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odata[0]),
    .count(cnt[0]), .almost_full(af[0]), .almost_empty(ae[0]), .drop_count(dcnt[0]),
    .stats_clr(stats_clr), .high_water(hw[0]));

  stream_fifo #(.WIDTH(W), .DEPTH(16), .DROP_ON_FULL(1)) u_drop (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odata[1]),
    .count(cnt[1]), .almost_full(af[1]), .almost_empty(ae[1]), .drop_count(dcnt[1]),
    .stats_clr(stats_clr), .high_water(hw[1]));

  stream_fifo #(.WIDTH(W), .DEPTH(12), .DROP_ON_FULL(0)) u_d12 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .out_valid(ovld[2]), .out_ready(out_ready), .out_data(odata[2]),
    .count(cnt[2]), .almost_full(af[2]), .almost_empty(ae[2]), .drop_count(dcnt[2]),
    .stats_clr(stats_clr), .high_water(hw[2]));

  // Reference model: per instance, an ordered list of held entries.
  int           m_depth [3] = '{16, 16, 12};
  bit           m_drop  [3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] m_list  [3][16];
  int           m_size  [3];
  longint       m_dc    [3];
  int           m_hw    [3];

  task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_size[i] = 0;
      m_dc[i]   = 0;
      m_hw[i]   = 0;
    end
  endtask

  // Apply one clock's worth of the FIFO rules using the current inputs.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit full, do_pop, do_push, do_drop;
      full    = (m_size[i] == m_depth[i]);
      do_pop  = !flush && (m_size[i] > 0) && out_ready;
      do_push = !flush && in_valid && !full;
      do_drop = !flush && m_drop[i] && in_valid && full;
      if (flush) m_size[i] = 0;
      if (do_pop) begin
        for (int j = 0; j < m_size[i] - 1; j++) m_list[i][j] = m_list[i][j+1];
        m_size[i]--;
      end
      if (do_push) begin
        m_list[i][m_size[i]] = in_data;
        m_size[i]++;
      end
      if (STATS && stats_clr) m_dc[i] = 0;
      else if (do_drop && m_dc[i] < 64'hFFFF_FFFF) m_dc[i]++;
      if (STATS && stats_clr) m_hw[i] = 0;
      else if (STATS && m_size[i] > m_hw[i]) m_hw[i] = m_size[i];
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_count"}, i, W'(cnt[i]), W'(m_size[i]));
      chk({tag, "_out_valid"}, i, W'(ovld[i]), W'(m_size[i] > 0));
      chk({tag, "_in_ready"}, i, W'(rdy[i]), W'(m_drop[i] ? 1 : (m_size[i] < m_depth[i])));
      chk({tag, "_almost_full"}, i, W'(af[i]), W'(m_size[i] >= m_depth[i] - 2));
      chk({tag, "_almost_empty"}, i, W'(ae[i]), W'(m_size[i] <= 2));
      chk({tag, "_drop_count"}, i, W'(dcnt[i]), W'(m_dc[i]));
      chk({tag, "_high_water"}, i, W'(hw[i]), W'(m_hw[i]));
      if (m_size[i] > 0) chk({tag, "_out_data"}, i, odata[i], m_list[i][0]);
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic         iv;
    logic         ordy;
    logic [W-1:0] data;
    logic [4:0]   exp_cnt0;
    logic         exp_rdy0;
    logic         exp_af0;
    logic [4:0]   exp_cnt1;
    logic [31:0]  exp_drop1;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // Fill vectors: push 0..19 with the consumer stalled.
    for (int k = 0; k < 20; k++) begin
      int c;
      c = (k + 1 < 16) ? k + 1 : 16;
      tbl[k].iv        = 1'b1;
      tbl[k].ordy      = 1'b0;
      tbl[k].data      = W'(k);
      tbl[k].exp_cnt0  = 5'(c);
      tbl[k].exp_rdy0  = (c < 16);
      tbl[k].exp_af0   = (c >= 14);
      tbl[k].exp_cnt1  = 5'(c);
      tbl[k].exp_drop1 = (k + 1 > 16) ? 32'(k + 1 - 16) : 32'd0;
    end

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    stats_clr = 1'b0; in_data = '0;
    model_reset();
    #12;
    check_all("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven backpressure / drop fill.
    for (int k = 0; k < 20; k++) begin
      in_valid  = tbl[k].iv;
      out_ready = tbl[k].ordy;
      in_data   = tbl[k].data;
      step("fill");
      chk("tbl_count_bp", 0, W'(cnt[0]), W'(tbl[k].exp_cnt0));
      chk("tbl_in_ready_bp", 0, W'(rdy[0]), W'(tbl[k].exp_rdy0));
      chk("tbl_almost_full_bp", 0, W'(af[0]), W'(tbl[k].exp_af0));
      chk("tbl_count_drop", 1, W'(cnt[1]), W'(tbl[k].exp_cnt1));
      chk("tbl_drop_count", 1, W'(dcnt[1]), W'(tbl[k].exp_drop1));
    end
    chk("fill_drop_zero_bp", 0, W'(dcnt[0]), W'(0));

    // Drain: drop-mode instance must yield 0..15 in order.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_order", 1, odata[1], W'(k));
      step("drain");
    end
    chk("drained_empty", 1, W'(ovld[1]), W'(0));

    // Simultaneous push/pop holding count at 5.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data = W'(100 + k);
      step("prefill5");
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = W'(200 + k);
      step("pushpop5");
      chk("pushpop_count", 0, W'(cnt[0]), W'(5));
    end

    // Fill to full, then push+pop at full: pop happens, push blocked.
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_data = W'(300 + k);
      step("fill_full");
    end
    chk("full_count", 0, W'(cnt[0]), W'(16));
    out_ready = 1'b1;
    in_data   = W'(999);
    step("full_pushpop");
    chk("full_pushpop_count", 0, W'(cnt[0]), W'(15));

    // Flush at count 7 with a concurrent push.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    step("pre_flush");
    flush = 1'b0; stats_clr = 1'b1;
    step("pre_clr");
    stats_clr = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_data = W'(400 + k);
      step("fill7");
    end
    begin
      logic [31:0] dc_before;
      dc_before = dcnt[1];
      flush = 1'b1; in_data = W'(777);
      step("flush");
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 0, W'(cnt[0]), W'(0));
      chk("flush_out_valid", 0, W'(ovld[0]), W'(0));
      chk("flush_drop_kept", 1, W'(dcnt[1]), W'(dc_before));
    end
`ifdef STREAM_FIFO_STATS_EN
    chk("flush_hw_kept", 0, W'(hw[0]), W'(7));
    stats_clr = 1'b1;
    step("stats_clr");
    stats_clr = 1'b0;
    chk("stats_clr_hw", 0, W'(hw[0]), W'(0));
`endif

    // Randomised streaming across pointer wrap (DEPTH=12 and 16).
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      in_data   = {$urandom, $urandom};
      flush     = ($urandom_range(0, 99) == 0);
      stats_clr = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    flush = 1'b0; stats_clr = 1'b0;

    // Asynchronous reset with count 9.
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step("pre_rst_flush");
    flush = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_data = W'(500 + k);
      step("fill9");
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 0, W'(cnt[0]), W'(9));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_data = W'(8'hA5);
    step("post_rst_push");
    in_valid = 1'b0;
    chk("post_rst_data", 0, odata[0], W'(8'hA5));
    chk("post_rst_valid", 0, W'(ovld[0]), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
